// File: rtl/led_matrix_scan_ctrl.sv
// Column-scanning LED matrix output stage: holds an 8x8 frame and drives one column at a time.
// Each column has a blanking gap, then a dwell window with global PWM brightness.
module led_matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 256,
    parameter int BLANK_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [63:0] frame_in,
    input  logic        frame_valid,
    input  logic [3:0]  brightness,
    output logic        frame_ack,
    output logic        frame_ovr,
    output logic        frame_sync,
    output logic [7:0]  col_sel,
    output logic [7:0]  row_data
);

    typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWM_STEP   = CNT_W'(DWELL_CYCLES / 16);

    state_t           state, state_nxt;
    logic [2:0]       col, col_nxt;
    logic [CNT_W-1:0] phase, phase_nxt;
    logic [63:0]      active, pending;
    logic             pend_v;
    logic [3:0]       bright_r;
    logic             boundary;
    logic [CNT_W-1:0] pwm_thr;

    // First cycle of column 0 blanking marks the frame boundary.
    assign boundary = (state == BLANK) && (col == 3'd0) && (phase == '0);
    assign pwm_thr  = CNT_W'(bright_r) * PWM_STEP;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            col   <= 3'd0;
            phase <= '0;
        end else begin
            state <= state_nxt;
            col   <= col_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        col_nxt   = col;
        phase_nxt = phase + 1'b1;
        if (!enable) begin
            state_nxt = IDLE;
            col_nxt   = 3'd0;
            phase_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = BLANK;
                    col_nxt   = 3'd0;
                    phase_nxt = '0;
                end
                BLANK: begin
                    if (phase == BLANK_LAST) begin
                        state_nxt = DWELL;
                        phase_nxt = '0;
                    end
                end
                DWELL: begin
                    if (phase == DWELL_LAST) begin
                        state_nxt = BLANK;
                        col_nxt   = col + 3'd1;   // 7 wraps to 0: next frame
                        phase_nxt = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    col_nxt   = 3'd0;
                    phase_nxt = '0;
                end
            endcase
        end
    end

    // Adoption uses the old pending value, so a capture on the boundary waits a frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active   <= '0;
            pending  <= '0;
            pend_v   <= 1'b0;
            bright_r <= 4'd0;
        end else begin
            if (boundary) begin
                bright_r <= brightness;
                if (pend_v) active <= pending;
            end
            if (frame_valid) begin
                pending <= frame_in;
                pend_v  <= 1'b1;
            end else if (boundary) begin
                pend_v  <= 1'b0;
            end
        end
    end

    always_comb begin
        col_sel  = 8'h00;
        row_data = 8'h00;
        if (state == DWELL) begin
            col_sel = 8'b1 << col;
            if (phase < pwm_thr) row_data = active[{col, 3'b000} +: 8];
        end
    end

    assign frame_sync = boundary;
    assign frame_ack  = boundary && pend_v;
    assign frame_ovr  = frame_valid && pend_v && !boundary;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Randomized bench for led_matrix_scan_ctrl; a time-in-frame reference model predicts every output each cycle.
module tb_led_matrix_scan_ctrl;

    localparam int DW  = 32;
    localparam int BL  = 2;
    localparam int COLP = DW + BL;
    localparam int FRP  = 8 * COLP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [63:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic [3:0]  brightness = 4'd0;
    logic        frame_ack, frame_ovr, frame_sync;
    logic [7:0]  col_sel, row_data;

    led_matrix_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frame_in(frame_in),
        .frame_valid(frame_valid), .brightness(brightness), .frame_ack(frame_ack),
        .frame_ovr(frame_ovr), .frame_sync(frame_sync), .col_sel(col_sel), .row_data(row_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: scanning flag, cycle offset within frame, pending/active frames.
    bit          m_run = 1'b0;
    int          m_t = 0;
    bit          m_pv = 1'b0;
    logic [63:0] m_pend = '0;
    logic [63:0] m_act = '0;
    logic [3:0]  m_br = 4'd0;

    bit count_lit = 1'b0;
    int lit_cycles = 0;
    int ack_seen = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 25)
                $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called just after negedge with inputs set: check, clock, advance the model.
    task automatic tick();
        logic [7:0] e_col, e_row;
        logic e_sync, e_ack, e_ovr;
        int c, off;
        #1;
        e_col = 8'h00; e_row = 8'h00; e_sync = 1'b0; e_ack = 1'b0;
        if (m_run) begin
            c   = m_t / COLP;
            off = m_t % COLP;
            e_sync = (m_t == 0);
            e_ack  = (m_t == 0) && m_pv;
            if (off >= BL) begin
                e_col = 8'(1 << c);
                if ((off - BL) < int'(m_br) * (DW / 16)) e_row = m_act[c*8 +: 8];
            end
        end
        e_ovr = frame_valid && m_pv && !(m_run && m_t == 0);
        chk("col_sel", 64'(col_sel), 64'(e_col));
        chk("row_data", 64'(row_data), 64'(e_row));
        chk("frame_sync", 64'(frame_sync), 64'(e_sync));
        chk("frame_ack", 64'(frame_ack), 64'(e_ack));
        chk("frame_ovr", 64'(frame_ovr), 64'(e_ovr));
        if (count_lit && row_data != 8'h00) lit_cycles++;
        if (frame_ack === 1'b1) ack_seen++;
        @(posedge clk);
        if (!rst_n) begin
            m_run = 1'b0; m_t = 0; m_pv = 1'b0;
            m_pend = '0; m_act = '0; m_br = 4'd0;
        end else begin
            if (m_run && m_t == 0) begin
                m_br = brightness;
                if (m_pv) begin
                    m_act = m_pend;
                    m_pv  = 1'b0;
                end
            end
            if (frame_valid) begin
                m_pend = frame_in;
                m_pv   = 1'b1;
            end
            if (!enable) begin
                m_run = 1'b0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FRP;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();                       // reset state checked here

        // Directed: diagonal frame at full brightness.
        rst_n = 1'b1; enable = 1'b1; brightness = 4'd15;
        frame_valid = 1'b1; frame_in = 64'h8040201008040201;
        tick();
        frame_valid = 1'b0;
        repeat (FRP) tick();
        count_lit = 1'b1;
        repeat (FRP) tick();
        count_lit = 1'b0;
        chk("lit_cycles_frame2", 64'(lit_cycles), 64'(8 * 30));

        // Directed: brightness 1 gives 2 lit cycles per dwell after next boundary.
        brightness = 4'd1;
        repeat (FRP) tick();
        lit_cycles = 0; count_lit = 1'b1;
        repeat (FRP) tick();
        count_lit = 1'b0;
        chk("lit_cycles_bright1", 64'(lit_cycles), 64'(8 * 2));

        // Directed: reset mid-dwell with a pending frame discards it.
        frame_valid = 1'b1; frame_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        frame_valid = 1'b0;
        repeat (50) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; brightness = 4'd15; ack_seen = 0;
        repeat (2 * FRP) tick();
        chk("no_ack_after_reset", 64'(ack_seen), 64'd0);

        // Random phase.
        for (int i = 0; i < 18000; i++) begin
            rst_n = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            if ($urandom_range(0, 299) == 0) brightness = 4'($urandom);
            frame_valid = ($urandom_range(0, 99) == 0) ||
                          (m_run && m_t == 0 && $urandom_range(0, 2) == 0);
            frame_in = {$urandom, $urandom};
            tick();
        end
        frame_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
